// File: rtl/bp_table_ctrl_if.sv
// Update-request handshake between the pipeline's M stage and the
// branch-predictor table controller.
interface bp_table_ctrl_if;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;

    modport master (output upd_valid, output upd_pc, output upd_taken, input upd_ready);
    modport slave  (input upd_valid, input upd_pc, input upd_taken, output upd_ready);
endinterface

// File: rtl/bp_table_ctrl.sv
// Sole writer of the two-level branch predictor tables (BHT of per-branch
// histories, PHT of 2-bit counters): power-up/clear sweeps and queued RMW updates.
module bp_table_ctrl #(
    parameter int BHT_DEPTH = 10,
    parameter int PHT_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    bp_table_ctrl_if.slave       upd,
    input  logic                 i_clr_req,
    output logic                 o_init_done,
    output logic [BHT_DEPTH-1:0] o_bht_addr,
    output logic                 o_bht_we,
    output logic [PHT_DEPTH-1:0] o_bht_wdata,
    input  logic [PHT_DEPTH-1:0] i_bht_rdata,
    output logic [PHT_DEPTH-1:0] o_pht_addr,
    output logic                 o_pht_we,
    output logic [1:0]           o_pht_wdata,
    input  logic [1:0]           i_pht_rdata
);

    typedef enum logic [1:0] {SWEEP, IDLE, PHT_RD, WRITE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [BHT_DEPTH-1:0]   r_idx;
    logic                   r_init_done;
    logic                   r_clr_pend;
    logic [BHT_DEPTH-1:0]   r_bht_addr, w_bht_addr;
    logic [PHT_DEPTH-1:0]   r_pht_addr, w_pht_addr;

    // Only pc[BHT_DEPTH+1:2] ever indexes a table; the PHT bits are a subset.
    logic [BHT_DEPTH-1:0]   r_fifo_pc [2];
    logic                   r_fifo_taken [2];
    logic                   r_wr_ptr, r_rd_ptr;
    logic [1:0]             r_count;
    logic                   w_full, w_empty, w_push, w_pop, w_flush;
    logic                   w_unused_pc;

    logic [BHT_DEPTH-1:0]   r_pc;
    logic                   r_taken;
    logic [PHT_DEPTH-2:0]   r_hist;

    // Encoding 00 SNT, 01 WNT, 11 WT, 10 ST; saturates at both ends.
    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b11:   nxt = taken ? 2'b10 : 2'b01;
            default: nxt = taken ? 2'b10 : 2'b11;
        endcase
        return nxt;
    endfunction

    assign w_full          = (r_count == 2'd2);
    assign w_empty         = (r_count == 2'd0);
    assign upd.upd_ready   = r_init_done & ~w_full & ~r_clr_pend;
    assign w_push          = upd.upd_valid & upd.upd_ready;
    assign w_unused_pc     = ^{upd.upd_pc[31:BHT_DEPTH+2], upd.upd_pc[1:0]};
    assign o_init_done     = r_init_done;
    assign o_bht_addr      = w_bht_addr;
    assign o_pht_addr      = w_pht_addr;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_bht_addr  = r_bht_addr;
        w_pht_addr  = r_pht_addr;
        o_bht_we    = 1'b0;
        o_bht_wdata = '0;
        o_pht_we    = 1'b0;
        o_pht_wdata = 2'b00;
        case (r_state)
            SWEEP: begin
                w_bht_addr = r_idx;
                o_bht_we   = 1'b1;
                if ((r_idx >> PHT_DEPTH) == '0) begin
                    w_pht_addr  = r_idx[PHT_DEPTH-1:0];
                    o_pht_we    = 1'b1;
                    o_pht_wdata = 2'b11;
                end
                if (r_idx == '1)
                    w_state_nxt = IDLE;
            end
            IDLE: begin
                if (r_clr_pend) begin
                    w_flush     = 1'b1;
                    w_state_nxt = SWEEP;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_bht_addr  = r_fifo_pc[r_rd_ptr];
                    w_state_nxt = PHT_RD;
                end
            end
            PHT_RD: begin
                w_pht_addr  = i_bht_rdata ^ r_pc[PHT_DEPTH-1:0];
                w_state_nxt = WRITE;
            end
            WRITE: begin
                o_bht_we    = 1'b1;
                o_bht_wdata = {r_hist, r_taken};
                o_pht_we    = 1'b1;
                o_pht_wdata = f_ctr_next(i_pht_rdata, r_taken);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = SWEEP;
        endcase
        // The RAMs must not see a write on the edge that resets this block.
        if (rst) begin
            o_bht_we = 1'b0;
            o_pht_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SWEEP;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_bht_addr  <= '0;
            r_pht_addr  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bht_addr <= w_bht_addr;
            r_pht_addr <= w_pht_addr;
            r_clr_pend <= i_clr_req | (r_clr_pend & ~w_flush);
            if (r_state == SWEEP) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == '1)
                    r_init_done <= 1'b1;
            end
            if (w_flush) begin
                r_count     <= 2'd0;
                r_wr_ptr    <= 1'b0;
                r_rd_ptr    <= 1'b0;
                r_idx       <= '0;
                r_init_done <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: FIFO storage and working registers carry no reset; r_count and r_state decide when they are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= upd.upd_pc[BHT_DEPTH+1:2];
            r_fifo_taken[r_wr_ptr] <= upd.upd_taken;
        end
        if (w_pop) begin
            r_pc    <= r_fifo_pc[r_rd_ptr];
            r_taken <= r_fifo_taken[r_rd_ptr];
        end
        if (r_state == PHT_RD)
            r_hist <= i_bht_rdata[PHT_DEPTH-2:0];
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: RAM models, reference predictor
// model and a write scoreboard, driven by a vector table and corner sequences.
module tb_bp_table_ctrl;
    localparam int BD = 10;
    localparam int PD = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_table_ctrl_if bus();
    logic          clr_req, init_done, bht_we, pht_we;
    logic [BD-1:0] bht_addr;
    logic [PD-1:0] bht_wdata, bht_rdata, pht_addr;
    logic [1:0]    pht_wdata, pht_rdata;

    bp_table_ctrl #(.BHT_DEPTH(BD), .PHT_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .upd(bus),
        .i_clr_req(clr_req), .o_init_done(init_done),
        .o_bht_addr(bht_addr), .o_bht_we(bht_we), .o_bht_wdata(bht_wdata), .i_bht_rdata(bht_rdata),
        .o_pht_addr(pht_addr), .o_pht_we(pht_we), .o_pht_wdata(pht_wdata), .i_pht_rdata(pht_rdata)
    );

    // Synchronous-read RAMs: data appears one cycle after the address.
    logic [PD-1:0] bht_mem [2**BD];
    logic [1:0]    pht_mem [2**PD];
    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_addr] <= bht_wdata;
        if (pht_we) pht_mem[pht_addr] <= pht_wdata;
        bht_rdata <= bht_mem[bht_addr];
        pht_rdata <= pht_mem[pht_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [BD-1:0] baddr;
        logic [PD-1:0] bwd;
        logic [PD-1:0] paddr;
        logic [1:0]    pwd;
    } exp_t;

    typedef struct {
        logic [31:0]   pc;
        logic          taken;
        logic [BD-1:0] baddr;
        logic [PD-1:0] bwd;
        logic [PD-1:0] paddr;
        logic [1:0]    pwd;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference tables, updated when a request is issued.
    logic [PD-1:0] ref_bht [2**BD];
    logic [1:0]    ref_pht [2**PD];

    function automatic int lvl(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] enc(input int l);
        case (l)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic void model_reset();
        foreach (ref_bht[i]) ref_bht[i] = '0;
        foreach (ref_pht[i]) ref_pht[i] = 2'b11;
    endfunction

    function automatic exp_t predict(input logic [31:0] pc, input logic taken);
        exp_t          e;
        logic [BD-1:0] bi;
        logic [PD-1:0] h, pi;
        int            l;
        bi = pc[BD+1:2];
        h  = ref_bht[bi];
        pi = h ^ pc[PD+1:2];
        l  = lvl(ref_pht[pi]);
        if (taken) l = (l == 3) ? 3 : l + 1;
        else       l = (l == 0) ? 0 : l - 1;
        e.baddr = bi;
        e.bwd   = {h[PD-2:0], taken};
        e.paddr = pi;
        e.pwd   = enc(l);
        ref_bht[bi] = e.bwd;
        ref_pht[pi] = e.pwd;
        return e;
    endfunction

    // Scoreboard consumer: every update write must match the oldest issued request.
    always @(negedge clk) begin
        if (!rst && init_done && (bht_we || pht_we)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("update_write", {bht_we, pht_we, bht_addr, bht_wdata, pht_addr, pht_wdata},
                      {2'b11, mon_e});
            end
        end
    end

    int last_stall;

    task automatic send(input logic [31:0] pc, input logic taken, input exp_t e);
        int waits = 0;
        @(negedge clk);
        bus.upd_valid = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = taken;
        while (!bus.upd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        last_stall = waits;
        if (!bus.upd_ready) begin
            check("send_timeout", 1, 0);
            bus.upd_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(e);
            #1 bus.upd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Samples first, then steps: call with the DUT at sweep index 0, away from the edge.
    task automatic check_sweep(input string tag);
        int bad_we = 0, bad_addr = 0, bad_data = 0, bad_pht = 0, bad_flag = 0;
        for (int i = 0; i < 2**BD; i++) begin
            if (bht_we !== 1'b1)         bad_we++;
            if (bht_addr !== BD'(i))     bad_addr++;
            if (bht_wdata !== '0)        bad_data++;
            if (i < 2**PD) begin
                if (!(pht_we === 1'b1 && pht_addr === PD'(i) && pht_wdata === 2'b11)) bad_pht++;
            end else if (pht_we !== 1'b0) begin
                bad_pht++;
            end
            if (init_done !== 1'b0 || bus.upd_ready !== 1'b0) bad_flag++;
            @(negedge clk);
        end
        check({tag, "_bht_we"},     bad_we,   0);
        check({tag, "_bht_addr"},   bad_addr, 0);
        check({tag, "_bht_wdata"},  bad_data, 0);
        check({tag, "_pht_write"},  bad_pht,  0);
        check({tag, "_init_low"},   bad_flag, 0);
        check({tag, "_init_done"},  init_done, 1);
        check({tag, "_ready"},      bus.upd_ready, 1);
    endtask

    vec_t vecs[12];
    int   stalls[4];
    logic [31:0] b2b_pc[4];
    logic        b2b_tk[4];

    initial begin
        // {pc, taken, bht addr, bht wdata, pht addr, pht wdata} from cleared tables, in order.
        vecs[0]  = '{32'h0000_0010, 1'b1, 10'd4,    6'd1,  6'd4,  2'b10};
        vecs[1]  = '{32'h0000_0010, 1'b1, 10'd4,    6'd3,  6'd5,  2'b10};
        vecs[2]  = '{32'h0000_0010, 1'b1, 10'd4,    6'd7,  6'd7,  2'b10};
        vecs[3]  = '{32'h0000_0014, 1'b0, 10'd5,    6'd0,  6'd5,  2'b11};
        vecs[4]  = '{32'h0000_0014, 1'b0, 10'd5,    6'd0,  6'd5,  2'b01};
        vecs[5]  = '{32'h0000_0014, 1'b0, 10'd5,    6'd0,  6'd5,  2'b00};
        vecs[6]  = '{32'h0000_0014, 1'b0, 10'd5,    6'd0,  6'd5,  2'b00};
        vecs[7]  = '{32'h0000_0010, 1'b1, 10'd4,    6'd15, 6'd3,  2'b10};
        vecs[8]  = '{32'h0000_0010, 1'b1, 10'd4,    6'd31, 6'd11, 2'b10};
        vecs[9]  = '{32'h0000_002C, 1'b1, 10'd11,   6'd1,  6'd11, 2'b10};
        vecs[10] = '{32'h0000_002C, 1'b0, 10'd11,   6'd2,  6'd10, 2'b01};
        vecs[11] = '{32'hFFFF_FFFC, 1'b1, 10'd1023, 6'd1,  6'd63, 2'b10};

        b2b_pc[0] = 32'h0000_0100; b2b_tk[0] = 1'b1;
        b2b_pc[1] = 32'h0000_0200; b2b_tk[1] = 1'b0;
        b2b_pc[2] = 32'h0000_0100; b2b_tk[2] = 1'b1;
        b2b_pc[3] = 32'h0000_0300; b2b_tk[3] = 1'b1;

        bus.upd_valid = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_taken = 1'b0;
        clr_req       = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_init_done", init_done, 0);
        check("rst_ready",     bus.upd_ready, 0);
        check("rst_bht_we",    bht_we, 0);
        check("rst_pht_we",    pht_we, 0);

        // Power-up sweep.
        rst = 1'b0;
        #1;
        check_sweep("sweep0");
        model_reset();

        // Vector table, issued back to back.
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            void'(predict(vecs[i].pc, vecs[i].taken));
            e.baddr = vecs[i].baddr;
            e.bwd   = vecs[i].bwd;
            e.paddr = vecs[i].paddr;
            e.pwd   = vecs[i].pwd;
            send(vecs[i].pc, vecs[i].taken, e);
        end
        drain();

        // Four requests with no gaps: the FIFO fills and the fourth waits for the second pop.
        for (int k = 0; k < 4; k++) begin
            send(b2b_pc[k], b2b_tk[k], predict(b2b_pc[k], b2b_tk[k]));
            stalls[k] = last_stall;
        end
        check("b2b_stall_0", stalls[0], 0);
        check("b2b_stall_1", stalls[1], 0);
        check("b2b_stall_2", stalls[2], 0);
        check("b2b_stall_3", stalls[3], 2);
        drain();

        // Clear while the first update is in PHT_RD and a second is queued.
        send(32'h0000_0010, 1'b0, predict(32'h0000_0010, 1'b0));
        send(32'h0000_0014, 1'b1, predict(32'h0000_0014, 1'b1));
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check("clr_pend_blocks_ready", bus.upd_ready, 0);
        begin
            int w = 0;
            while (init_done && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("clr_sweep_start", init_done, 0);
        end
        check_sweep("sweep_clr");
        check("clr_discarded", sb.size(), 1);
        sb.delete();
        model_reset();

        // Tables must be back at their cleared values.
        send(32'h0000_0010, 1'b1, predict(32'h0000_0010, 1'b1));
        drain();

        // Reset pulse part-way through a sweep.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        repeat (500) @(negedge clk);
        check("midsweep_idx", bht_addr, 500);
        rst = 1'b1;
        #1;
        check("midsweep_rst_we", {bht_we, pht_we}, 2'b00);
        check("midsweep_rst_init", init_done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_sweep("sweep_rst");
        check("final_queue", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
